// File: rtl/mem_ctr_burst.sv
// Line-burst memory controller: byte-organised storage, fixed command-to-response latency.
// Optional per-byte write mask on port BE is enabled by defining MEM_CTR_BYTE_MASK_EN.
module mem_ctr_burst #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int LINE_BYTES = 16,
  parameter int MEM_BYTES  = 16384,
  parameter int LATENCY    = 100
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [1:0]          CMD,
  input  logic [ADDR_W-1:0]   ADDR,
  input  logic [DATA_W-1:0]   WDATA,
`ifdef MEM_CTR_BYTE_MASK_EN
  input  logic [DATA_W/8-1:0] BE,
`endif
  output logic [DATA_W-1:0]   RDATA,
  output logic                RESP,
  output logic                BUSY
);

  localparam int BPB    = DATA_W / 8;
  localparam int BEATS  = LINE_BYTES * 8 / DATA_W;
  localparam int LINES  = MEM_BYTES / LINE_BYTES;
  localparam int MEM_AW = $clog2(MEM_BYTES);
  localparam int LCW    = $clog2(LATENCY + 1);
  localparam int BCW    = $clog2(BEATS + 1);

  localparam logic [1:0] CmdRead  = 2'd2;
  localparam logic [1:0] CmdWrite = 2'd3;

  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 8");
  end
  if ((LINE_BYTES * 8) % DATA_W != 0) begin : g_bad_line
    $error("LINE_BYTES*8 must be a multiple of DATA_W");
  end
  if (MEM_BYTES % LINE_BYTES != 0) begin : g_bad_mem
    $error("MEM_BYTES must be a multiple of LINE_BYTES");
  end
  if (LATENCY < BEATS + 1) begin : g_bad_lat
    $error("LATENCY must be at least BEATS+1");
  end

  typedef enum logic [2:0] {StIdle, StWcap, StWait, StRburst, StWresp} state_e;

  state_e              state_q;
  logic                busy_q, resp_q, is_write_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [BCW-1:0]      bcnt_q;
  logic [LCW-1:0]      lcnt_q;
  logic [MEM_AW-1:0]   base_q;

  logic [7:0]          mem_q [MEM_BYTES];

  logic                cmd_acc;
  logic [31:0]         line_idx;
  logic [MEM_AW-1:0]   base_d, beat_addr, wr_addr;
  logic                mem_we;
  logic [BPB-1:0]      be_eff;
  logic [DATA_W-1:0]   rd_word;

`ifdef MEM_CTR_BYTE_MASK_EN
  assign be_eff = BE;
`else
  assign be_eff = '1;
`endif

  // Modulo on the line index makes out-of-range addresses wrap onto existing lines.
  always_comb begin
    cmd_acc   = (state_q == StIdle) && (CMD == CmdRead || CMD == CmdWrite);
    line_idx  = 32'(ADDR) % 32'(LINES);
    base_d    = MEM_AW'(line_idx * 32'(LINE_BYTES));
    beat_addr = base_q + MEM_AW'(bcnt_q) * MEM_AW'(BPB);
    wr_addr   = (state_q == StIdle) ? base_d : beat_addr;
    // Gating with RESET_N keeps an edge seen while reset is held from writing a beat.
    mem_we    = RESET_N && ((cmd_acc && CMD == CmdWrite) || state_q == StWcap);
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < BPB; i++) begin
      rd_word[8*i +: 8] = mem_q[beat_addr + MEM_AW'(i)];
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int i = 0; i < BPB; i++) begin
        if (be_eff[i]) mem_q[wr_addr + MEM_AW'(i)] <= WDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      resp_q     <= 1'b0;
      is_write_q <= 1'b0;
      rdata_q    <= '0;
      bcnt_q     <= '0;
      lcnt_q     <= '0;
      base_q     <= '0;
    end else begin
      resp_q  <= 1'b0;
      rdata_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (cmd_acc) begin
            busy_q     <= 1'b1;
            base_q     <= base_d;
            is_write_q <= (CMD == CmdWrite);
            // Expires at E0+LATENCY: loaded with LATENCY-1, checked for zero.
            lcnt_q     <= LCW'(LATENCY - 1);
            if (CMD == CmdWrite) begin
              state_q <= StWcap;
              bcnt_q  <= BCW'(1);
            end else begin
              state_q <= StWait;
              bcnt_q  <= '0;
            end
          end
        end
        StWcap: begin
          lcnt_q <= lcnt_q - 1'b1;
          if (bcnt_q >= BCW'(BEATS - 1)) begin
            state_q <= StWait;
            bcnt_q  <= '0;
          end else begin
            bcnt_q <= bcnt_q + 1'b1;
          end
        end
        StWait: begin
          if (lcnt_q == '0) begin
            resp_q <= 1'b1;
            if (is_write_q) begin
              state_q <= StWresp;
            end else begin
              state_q <= StRburst;
              rdata_q <= rd_word;
              bcnt_q  <= BCW'(1);
            end
          end else begin
            lcnt_q <= lcnt_q - 1'b1;
          end
        end
        StRburst: begin
          if (bcnt_q == BCW'(BEATS)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            bcnt_q  <= '0;
          end else begin
            resp_q  <= 1'b1;
            rdata_q <= rd_word;
            bcnt_q  <= bcnt_q + 1'b1;
          end
        end
        StWresp: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign RDATA = rdata_q;
  assign RESP  = resp_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_mem_ctr_burst.sv
// Scoreboard bench for mem_ctr_burst: drivers push expected responses, a monitor checks them.
module tb_mem_ctr_burst;

  localparam int LAT   = 12;
  localparam int BEATS = 8;
  localparam int LINES = 16;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [1:0]  CMD;
  logic [5:0]  ADDR;
  logic [15:0] WDATA;
  logic [1:0]  be_v;
  logic [15:0] RDATA;
  logic        RESP;
  logic        BUSY;

  mem_ctr_burst #(
    .ADDR_W     (6),
    .DATA_W     (16),
    .LINE_BYTES (16),
    .MEM_BYTES  (256),
    .LATENCY    (LAT)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .CMD     (CMD),
    .ADDR    (ADDR),
    .WDATA   (WDATA),
`ifdef MEM_CTR_BYTE_MASK_EN
    .BE      (be_v),
`endif
    .RDATA   (RDATA),
    .RESP    (RESP),
    .BUSY    (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    bit          chk;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          junk_mode = 0;
  logic [7:0]  mdl [256];
  logic [15:0] wbeats [8];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every cycle either pops one expected response or checks RDATA is idle-zero.
  always @(negedge CLK) begin
    if (RESP === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got RESP=1 want none (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_cycle", cyc, mon_e.cyc);
        if (mon_e.chk) chk("rdata", {16'h0, RDATA}, {16'h0, mon_e.data});
      end
    end else begin
      chk("rdata_idle_zero", {16'h0, RDATA}, 32'h0);
    end
  end

  task automatic wait_idle(input int end_cyc);
    int n;
    n = 0;
    @(negedge CLK);
    while (BUSY === 1'b1 && n < 200) begin
      if (junk_mode == 1) begin
        CMD  = n[0] ? 2'd1 : 2'd2;
        ADDR = 6'd3;
      end else if (junk_mode == 2) begin
        CMD   = 2'd3;
        ADDR  = 6'd5;
        WDATA = 16'($urandom);
      end
      n++;
      @(negedge CLK);
    end
    CMD = 2'd0;
    chk("busy_drop_cycle", cyc, end_cyc);
  endtask

  task automatic write_line(input int line, input int nbeats_kept);
    int e0;
    int base;
    e0   = cyc + 1;
    base = (line % LINES) * 16;
    for (int k = 0; k < nbeats_kept; k++) begin
      for (int b = 0; b < 2; b++) begin
`ifdef MEM_CTR_BYTE_MASK_EN
        if (be_v[b]) mdl[base + 2*k + b] = wbeats[k][8*b +: 8];
`else
        mdl[base + 2*k + b] = wbeats[k][8*b +: 8];
`endif
      end
    end
    exp_q.push_back('{cyc: e0 + LAT, chk: 1'b0, data: 16'h0});
    CMD   = 2'd3;
    ADDR  = 6'(line);
    WDATA = wbeats[0];
    @(posedge CLK); #1;
    CMD = 2'd0;
    chk("busy_after_e0", {31'h0, BUSY}, 32'h1);
    for (int k = 1; k < BEATS; k++) begin
      WDATA = wbeats[k];
      @(posedge CLK); #1;
    end
    wait_idle(e0 + LAT + 1);
  endtask

  task automatic read_line(input int line);
    int e0;
    int base;
    e0   = cyc + 1;
    base = (line % LINES) * 16;
    for (int k = 0; k < BEATS; k++) begin
      exp_q.push_back('{cyc: e0 + LAT + k, chk: 1'b1,
                        data: {mdl[base + 2*k + 1], mdl[base + 2*k]}});
    end
    CMD  = 2'd2;
    ADDR = 6'(line);
    @(posedge CLK); #1;
    CMD = 2'd0;
    chk("busy_after_e0", {31'h0, BUSY}, 32'h1);
    wait_idle(e0 + LAT + BEATS);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    RESET_N = 1'b0;
    CMD     = 2'd0;
    ADDR    = '0;
    WDATA   = '0;
    be_v    = 2'b11;
    #2;
    chk("reset_resp", {31'h0, RESP}, 32'h0);
    chk("reset_busy", {31'h0, BUSY}, 32'h0);
    chk("reset_rdata", {16'h0, RDATA}, 32'h0);
    #10 RESET_N = 1'b1;

    // Write line 5 on the first edge after reset; junk writes while busy must be dropped.
    for (int k = 0; k < BEATS; k++) wbeats[k] = 16'(k * 16'h0202 + 16'h0100);
    junk_mode = 2;
    write_line(5, BEATS);

    // Read line 5 with READ_LINE/reserved junk while busy, then an immediate second read.
    junk_mode = 1;
    read_line(5);
    junk_mode = 0;
    read_line(5);

    // Line count + 5 wraps onto line 5.
    read_line(LINES + 5);

    // Prefill line 2, then abort an AAAA write with reset at E0+3.
    for (int k = 0; k < BEATS; k++) wbeats[k] = 16'(16'hC0C0 + k);
    write_line(2, BEATS);
    for (int b = 0; b < 3; b++) begin
      mdl[32 + 2*b]     = 8'hAA;
      mdl[32 + 2*b + 1] = 8'hAA;
    end
    e0    = cyc + 1;
    CMD   = 2'd3;
    ADDR  = 6'd2;
    WDATA = 16'hAAAA;
    @(posedge CLK); #1;
    CMD = 2'd0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET_N = 1'b0;
    #1;
    chk("abort_reset_busy", {31'h0, BUSY}, 32'h0);
    chk("abort_reset_resp", {31'h0, RESP}, 32'h0);
    @(posedge CLK); #1;
    chk("abort_edge_count", cyc, e0 + 3);
    RESET_N = 1'b1;
    read_line(2);

`ifdef MEM_CTR_BYTE_MASK_EN
    for (int k = 0; k < BEATS; k++) wbeats[k] = 16'hFFFF;
    be_v = 2'b01;
    write_line(5, BEATS);
    be_v = 2'b11;
    read_line(5);
    chk("mask_model_beat0", {16'h0, mdl[81], mdl[80]}, 32'h01FF);
`endif

    repeat (20) @(negedge CLK);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
